// File: rtl/vxe_mem_hub_us_arb.sv
// Round-robin arbiter feeding one memory-hub master request FIFO from NCLI
// client request FIFOs, with a bounded sticky burst per client.
module vxe_mem_hub_us_arb #(
  parameter int NCLI      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NCLI-1:0]    i_rqa_vld,
  input  logic [NCLI*44-1:0] i_rqa,
  output logic [NCLI-1:0]    o_rqa_rd,
  input  logic               i_m_rqa_rdy,
  output logic [43:0]        o_m_rqa,
  output logic               o_m_rqa_wr,
  output logic               o_idle
);

  localparam int LW  = (NCLI > 1) ? $clog2(NCLI) : 1;
  localparam int LW1 = LW + 1;
  localparam logic [3:0]    MAXB     = 4'(MAX_BURST);
  localparam logic [LW-1:0] LAST_CLI = LW'(NCLI - 1);
  localparam logic [LW:0]   NCLI_W   = LW1'(NCLI);

  logic          hold_vld;
  logic [43:0]   hold_q;
  logic [LW-1:0] last_gnt;
  logic [3:0]    burst_cnt;

  logic [LW-1:0] gnt;
  logic          sticky;
  logic          accept;
  logic          found;
  logic [LW:0]   cand;
  logic [43:0]   head [NCLI];

  always_comb begin
    for (int k = 0; k < NCLI; k++) begin
      head[k] = i_rqa[44*k +: 44];
    end
  end

  // burst_cnt==0 only after reset: no client owns the port yet, so the first
  // grant rotates from last_gnt+1 (client 0) instead of sticking to NCLI-1.
  assign sticky = i_rqa_vld[last_gnt] && (burst_cnt != 4'd0) && (burst_cnt < MAXB);

  always_comb begin
    gnt   = last_gnt;
    found = 1'b0;
    cand  = '0;
    if (!sticky) begin
      for (int i = 1; i <= NCLI; i++) begin
        cand = {1'b0, last_gnt} + LW1'(i);
        if (cand >= NCLI_W) cand = cand - NCLI_W;
        if (!found && i_rqa_vld[cand[LW-1:0]]) begin
          gnt   = cand[LW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  // Handshakes: a client entry transfers when i_rqa_vld[k] & o_rqa_rd[k] at a
  // clock edge; the held entry transfers to the master when hold_vld &
  // i_m_rqa_rdy (o_m_rqa_wr). The hold register refills in the cycle it drains.
  assign accept = nrst & (|i_rqa_vld) & (~hold_vld | i_m_rqa_rdy);

  always_comb begin
    o_rqa_rd = '0;
    for (int k = 0; k < NCLI; k++) begin
      o_rqa_rd[k] = accept && (gnt == LW'(k));
    end
  end

  assign o_m_rqa    = hold_q;
  assign o_m_rqa_wr = hold_vld & i_m_rqa_rdy;
  assign o_idle     = ~hold_vld & ~(|i_rqa_vld);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_vld  <= 1'b0;
      hold_q    <= '0;
      last_gnt  <= LAST_CLI;
      burst_cnt <= 4'd0;
    end else if (accept) begin
      hold_q   <= head[gnt];
      hold_vld <= 1'b1;
      if (sticky) begin
        burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd1;
        last_gnt  <= gnt;
      end
    end else if (o_m_rqa_wr) begin
      hold_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vxe_mem_hub_us_arb.sv
// Directed bench for vxe_mem_hub_us_arb: instance a (MAX_BURST=4) and
// instance b (MAX_BURST=1) fed from modelled client FIFOs.
module tb_vxe_mem_hub_us_arb;

  logic         clk;
  logic         nrst;
  logic         rdy;
  logic [3:0]   vld_a, vld_b;
  logic [175:0] rqa_a, rqa_b;
  logic [3:0]   rd_a, rd_b;
  logic [43:0]  m_a, m_b;
  logic         wr_a, wr_b;
  logic         idle_a, idle_b;

  vxe_mem_hub_us_arb #(.NCLI(4), .MAX_BURST(4)) dut_a (
    .clk(clk), .nrst(nrst), .i_rqa_vld(vld_a), .i_rqa(rqa_a), .o_rqa_rd(rd_a),
    .i_m_rqa_rdy(rdy), .o_m_rqa(m_a), .o_m_rqa_wr(wr_a), .o_idle(idle_a));

  vxe_mem_hub_us_arb #(.NCLI(4), .MAX_BURST(1)) dut_b (
    .clk(clk), .nrst(nrst), .i_rqa_vld(vld_b), .i_rqa(rqa_b), .o_rqa_rd(rd_b),
    .i_m_rqa_rdy(rdy), .o_m_rqa(m_b), .o_m_rqa_wr(wr_b), .o_idle(idle_b));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [43:0] qa [4][$];
  logic [43:0] qb [4][$];
  logic [43:0] exp_q [$];
  logic [43:0] exp_q_b [$];
  int          gla [$];
  int          glb [$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [3:0]  s_rd;
  logic        s_wr, s_idle;
  logic [43:0] s_m;

  function automatic logic [43:0] ent(input int c, input int n);
    return {6'(c), 1'(n & 1), 37'(32'h1000 * c + n + 1)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      vld_a[k] = (qa[k].size() != 0);
      rqa_a[44*k +: 44] = (qa[k].size() != 0) ? qa[k][0] : 44'd0;
      vld_b[k] = (qb[k].size() != 0);
      rqa_b[44*k +: 44] = (qb[k].size() != 0) ? qb[k][0] : 44'd0;
    end
  endtask

  task automatic fill_a(input int c, input int n);
    for (int i = 0; i < n; i++) qa[c].push_back(ent(c, i));
  endtask

  task automatic fill_b(input int c, input int n);
    for (int i = 0; i < n; i++) qb[c].push_back(ent(c, i));
  endtask

  // One cycle: drive heads, sample at negedge, score, then pop the client FIFOs.
  task automatic step();
    logic [3:0] pa, pb;
    drive();
    @(negedge clk);
    pa = rd_a; pb = rd_b;
    s_rd = rd_a; s_wr = wr_a; s_m = m_a; s_idle = idle_a;
    chk("onehot_a", 64'($onehot0(pa)), 64'd1);
    chk("onehot_b", 64'($onehot0(pb)), 64'd1);
    if (wr_a) begin
      chk("wr_expected_a", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("sb_a", 64'(m_a), 64'(exp_q.pop_front()));
    end
    if (wr_b) begin
      chk("wr_expected_b", 64'(exp_q_b.size() != 0), 64'd1);
      if (exp_q_b.size() != 0) chk("sb_b", 64'(m_b), 64'(exp_q_b.pop_front()));
    end
    for (int k = 0; k < 4; k++) begin
      if (pa[k]) begin
        chk("pop_vld_a", 64'(qa[k].size() != 0), 64'd1);
        gla.push_back(k);
        if (qa[k].size() != 0) exp_q.push_back(qa[k][0]);
      end
      if (pb[k]) begin
        chk("pop_vld_b", 64'(qb[k].size() != 0), 64'd1);
        glb.push_back(k);
        if (qb[k].size() != 0) exp_q_b.push_back(qb[k][0]);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (pa[k] && qa[k].size() != 0) void'(qa[k].pop_front());
      if (pb[k] && qb[k].size() != 0) void'(qb[k].pop_front());
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      qa[k].delete();
      qb[k].delete();
    end
    exp_q.delete(); exp_q_b.delete(); gla.delete(); glb.delete();
    drive();
    repeat (2) @(posedge clk);
    #2 nrst = 1'b1;
  endtask

  task automatic drain(input string tag);
    int left;
    for (int i = 0; i < 80; i++) begin
      left = exp_q.size() + exp_q_b.size();
      for (int k = 0; k < 4; k++) left += qa[k].size() + qb[k].size();
      if (left == 0 && !wr_a && !wr_b) break;
      step();
    end
    left = exp_q.size() + exp_q_b.size();
    for (int k = 0; k < 4; k++) left += qa[k].size() + qb[k].size();
    chk(tag, 64'(left), 64'd0);
  endtask

  int exp2 [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  int exp3 [4]  = '{1,3,1,3};
  int exp5 [7]  = '{0,0,1,1,1,1,1};

  initial begin
    nrst = 1'b0; rdy = 1'b1;
    vld_a = '0; vld_b = '0; rqa_a = '0; rqa_b = '0;

    // reset state
    #3;
    chk("rst_rd", 64'(rd_a), 64'd0);
    chk("rst_wr", 64'(wr_a), 64'd0);
    chk("rst_m", 64'(m_a), 64'd0);
    chk("rst_idle", 64'(idle_a), 64'd1);
    vld_a = 4'b0101;
    rqa_a[43:0] = ent(0, 0);
    #2;
    chk("rst_rd_vld", 64'(rd_a), 64'd0);
    chk("rst_idle_vld", 64'(idle_a), 64'd0);

    // single client 2, three entries
    do_reset();
    rdy = 1'b1;
    fill_a(2, 3);
    step(); chk("t1_rd0", 64'(s_rd), 64'b0100); chk("t1_wr0", 64'(s_wr), 64'd0);
    step(); chk("t1_rd1", 64'(s_rd), 64'b0100); chk("t1_wr1", 64'(s_wr), 64'd1);
    chk("t1_m1", 64'(s_m), 64'(ent(2, 0)));
    step(); chk("t1_rd2", 64'(s_rd), 64'b0100); chk("t1_wr2", 64'(s_wr), 64'd1);
    chk("t1_m2", 64'(s_m), 64'(ent(2, 1)));
    step(); chk("t1_rd3", 64'(s_rd), 64'd0); chk("t1_wr3", 64'(s_wr), 64'd1);
    chk("t1_m3", 64'(s_m), 64'(ent(2, 2)));
    step(); chk("t1_wr4", 64'(s_wr), 64'd0); chk("t1_idle", 64'(s_idle), 64'd1);

    // all clients valid, burst of 4 each
    do_reset();
    for (int c = 0; c < 4; c++) fill_a(c, 8);
    for (int i = 0; i < 40 && gla.size() < 17; i++) step();
    chk("t2_ngnt", 64'(gla.size() >= 17), 64'd1);
    for (int i = 0; i < 17 && i < gla.size(); i++) chk("t2_gnt", 64'(gla[i]), 64'(exp2[i]));
    drain("t2_drain");

    // MAX_BURST=1 alternation on instance b
    do_reset();
    fill_b(1, 4); fill_b(3, 4);
    for (int i = 0; i < 20 && glb.size() < 4; i++) step();
    chk("t3_ngnt", 64'(glb.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < glb.size(); i++) chk("t3_gnt", 64'(glb[i]), 64'(exp3[i]));
    drain("t3_drain");

    // backpressure
    do_reset();
    fill_a(0, 3);
    rdy = 1'b0;
    step(); chk("t4_rd_load", 64'(s_rd), 64'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_rd_bp", 64'(s_rd), 64'd0);
      chk("t4_wr_bp", 64'(s_wr), 64'd0);
      chk("t4_m_bp", 64'(s_m), 64'(ent(0, 0)));
    end
    rdy = 1'b1;
    step();
    chk("t4_wr_rel", 64'(s_wr), 64'd1);
    chk("t4_m_rel", 64'(s_m), 64'(ent(0, 0)));
    chk("t4_rd_rel", 64'(s_rd), 64'b0001);
    drain("t4_drain");

    // sticky release
    do_reset();
    fill_a(0, 2); fill_a(1, 5);
    for (int i = 0; i < 20 && gla.size() < 7; i++) step();
    chk("t5_ngnt", 64'(gla.size()), 64'd7);
    for (int i = 0; i < 7 && i < gla.size(); i++) chk("t5_gnt", 64'(gla[i]), 64'(exp5[i]));
    drain("t5_drain");

    // async reset with a held request under backpressure
    do_reset();
    fill_a(2, 2);
    rdy = 1'b0;
    step(); chk("t6_rd_load", 64'(s_rd), 64'b0100);
    rdy = 1'b1;
    nrst = 1'b0;
    #1;
    chk("t6_wr_rst", 64'(wr_a), 64'd0);
    chk("t6_m_rst", 64'(m_a), 64'd0);
    chk("t6_rd_rst", 64'(rd_a), 64'd0);
    exp_q.delete(); gla.delete();
    fill_a(0, 1);
    drive();
    #1;
    chk("t6_rd_rst2", 64'(rd_a), 64'd0);
    @(posedge clk);
    #2 nrst = 1'b1;
    step(); chk("t6_rd_first", 64'(s_rd), 64'b0001);
    step(); chk("t6_rd_second", 64'(s_rd), 64'b0100);
    chk("t6_m_first", 64'(s_m), 64'(ent(0, 0)));
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
